// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial addition controller.
package serial_add_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam int WIDTH_DEFAULT = 8;
   localparam int CNT_W         = $clog2(WIDTH_DEFAULT);

   // Bits needed for a bit counter running 0..width-1.
   function automatic int cnt_bits(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// Single-bit full adder built from two half adders with the carries ORed.
// This is the only combinational datapath element of the serial adder.

// Existing half adder cell: sum and carry of two bits.
module half_adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);

   // Plain XOR/AND half adder.
   always_comb begin
      s = a ^ b;
      c = a & b;
   end

endmodule

module serial_fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic s0;
   logic c0;
   logic c1;

   half_adder u_ha0 (
      .a (a),
      .b (b),
      .s (s0),
      .c (c0)
   );

   half_adder u_ha1 (
      .a (s0),
      .b (cin),
      .s (s),
      .c (c1)
   );

   // At most one half adder can generate a carry, so OR merges them.
   always_comb begin
      cout = c0 | c1;
   end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial addition controller: captures two operands on start, walks a
// single full adder cell LSB-first one bit per clock, then publishes the
// WIDTH-bit sum and carry-out together with a one-cycle done pulse.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = cnt_bits(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             cout_q, cout_d;

   logic             cell_s;
   logic             cell_c;

   serial_fa_cell u_cell (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .cin  (carry_q),
      .s    (cell_s),
      .cout (cell_c)
   );

   // Next-state logic: operand capture in IDLE, one bit per cycle in RUN,
   // and a single done cycle before returning to IDLE. Start is only
   // looked at in IDLE, so requests during RUN/DONE are dropped.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      cout_d  = cout_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               carry_d = 1'b0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d   = {cell_s, sum_q[WIDTH-1:1]};
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            carry_d = cell_c;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               cnt_d   = '0;
               cout_d  = cell_c;
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // All state and outputs are registered; reset wins over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cout_q  <= cout_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl with WIDTH=8: a vector table,
// a done-driven scoreboard, and hand-written multi-cycle sequences.
module tb_serial_add_ctrl;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] expSum;
      logic             expCout;
   } vector_t;

   typedef struct {
      logic [WIDTH-1:0] sum;
      logic             cout;
   } result_t;

   vector_t vectors[5];
   result_t expQueue[$];
   int      nChecks = 0;
   int      nFails  = 0;
   int      nDone   = 0;

   serial_add_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a start for one cycle and record the expected result.
   task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                input logic [WIDTH-1:0] es, input logic ec);
      start = 1'b1;
      a     = av;
      b     = bv;
      expQueue.push_back('{sum: es, cout: ec});
      tick();
      start = 1'b0;
   endtask

   // Called in cycle 1 of an operation; returns the cycle index of done.
   task automatic waitDone(output int cycles);
      cycles = 1;
      while (done !== 1'b1 && cycles < 40) begin
         tick();
         cycles++;
      end
      if (done !== 1'b1) begin
         nChecks++;
         nFails++;
         $display("[TB] FAIL doneTimeout: got no done after %0d cycles, expected done", cycles);
      end
   endtask

   // Scoreboard: every done pulse pops one expected result.
   initial begin
      result_t r;
      forever begin
         @(posedge clk);
         #2;
         if (done === 1'b1) begin
            nDone++;
            if (expQueue.size() == 0) begin
               nChecks++;
               nFails++;
               $display("[TB] FAIL unexpectedDone: got done=1, expected no pulse");
            end else begin
               r = expQueue.pop_front();
               checkOutput("sbSum", sum, r.sum);
               checkOutput("sbCout", cout, r.cout);
            end
         end
      end
   end

   initial begin
      int cyc;
      int snap;

      vectors[0] = '{a: 8'hFF, b: 8'h01, expSum: 8'h00, expCout: 1'b1};
      vectors[1] = '{a: 8'hFF, b: 8'hFF, expSum: 8'hFE, expCout: 1'b1};
      vectors[2] = '{a: 8'h00, b: 8'h00, expSum: 8'h00, expCout: 1'b0};
      vectors[3] = '{a: 8'h0F, b: 8'hF1, expSum: 8'h00, expCout: 1'b1};
      vectors[4] = '{a: 8'h80, b: 8'h7F, expSum: 8'hFF, expCout: 1'b0};

      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      tick();
      tick();
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstDone", done, 0);
      checkOutput("rstSum", sum, 0);
      checkOutput("rstCout", cout, 0);
      rst = 1'b0;
      tick();

      // Basic timing: busy over cycles 1..9, done exactly at cycle 9.
      applyStimulus(8'h35, 8'h4A, 8'h7F, 1'b0);
      for (int c = 1; c <= 10; c++) begin
         if (c > 1) tick();
         checkOutput($sformatf("t1Busy%0d", c), busy, (c <= 9) ? 1 : 0);
         checkOutput($sformatf("t1Done%0d", c), done, (c == 9) ? 1 : 0);
         if (c == 9) begin
            checkOutput("t1Sum", sum, 32'h7F);
            checkOutput("t1Cout", cout, 0);
         end
      end
      checkOutput("t1HoldSum", sum, 32'h7F);

      // Table-driven operations, back to back from IDLE.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(vectors[i].a, vectors[i].b, vectors[i].expSum, vectors[i].expCout);
         waitDone(cyc);
         checkOutput($sformatf("vecLatency%0d", i), cyc, WIDTH + 1);
         tick();
         checkOutput($sformatf("vecIdle%0d", i), busy, 0);
         checkOutput($sformatf("vecHoldSum%0d", i), sum, vectors[i].expSum);
         checkOutput($sformatf("vecHoldCout%0d", i), cout, vectors[i].expCout);
      end

      // Starts during RUN and DONE are ignored; start right after DONE is taken.
      snap = nDone;
      applyStimulus(8'h10, 8'h20, 8'h30, 1'b0);
      for (int c = 1; c <= 19; c++) begin
         if (c > 1) tick();
         if (c == 9) begin
            checkOutput("t4Done9", done, 1);
            checkOutput("t4Sum9", sum, 32'h30);
            checkOutput("t4Cout9", cout, 0);
         end
         if (c == 10) begin
            checkOutput("t4Busy10", busy, 0);
            checkOutput("t4Done10", done, 0);
         end
         if (c == 11) checkOutput("t4Busy11", busy, 1);
         if (c == 19) begin
            checkOutput("t4Done19", done, 1);
            checkOutput("t4Sum19", sum, 32'hFF);
         end
         start = (c == 3 || c == 9 || c == 10);
         a     = 8'hAA;
         b     = 8'h55;
         if (c == 10) expQueue.push_back('{sum: 8'hFF, cout: 1'b0});
      end
      start = 1'b0;
      tick();
      checkOutput("t4DoneCount", nDone - snap, 2);

      // Reset mid-RUN discards the operation without a done pulse.
      start = 1'b1;
      a     = 8'h80;
      b     = 8'h80;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("t5Busy", busy, 0);
      checkOutput("t5Done", done, 0);
      checkOutput("t5Sum", sum, 0);
      checkOutput("t5Cout", cout, 0);
      snap = nDone;
      for (int c = 0; c < 12; c++) tick();
      checkOutput("t5NoDone", nDone - snap, 0);
      checkOutput("t5IdleBusy", busy, 0);
      applyStimulus(8'h01, 8'h02, 8'h03, 1'b0);
      waitDone(cyc);
      checkOutput("t5Latency", cyc, WIDTH + 1);
      tick();

      // Start held high: one addition every WIDTH+2 cycles.
      snap = nDone;
      for (int k = 0; k < 3; k++) expQueue.push_back('{sum: 8'h10, cout: 1'b0});
      start = 1'b1;
      a     = 8'h0F;
      b     = 8'h01;
      for (int c = 1; c <= 29; c++) begin
         tick();
         checkOutput($sformatf("t6Done%0d", c), done, (c % 10 == 9) ? 1 : 0);
      end
      start = 1'b0;
      tick();
      checkOutput("t6DoneCount", nDone - snap, 3);

      checkOutput("queueEmpty", expQueue.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
